// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and the logic that drives it: operation
// state encodings and default geometry.
package fifo_pkg;

  // Operation state codes, identical to the FIFO next-state encodings
  localparam logic [2:0] INIT  = 3'b000;
  localparam logic [2:0] WRITE = 3'b001;
  localparam logic [2:0] READ  = 3'b010;
  localparam logic [2:0] NO_OP = 3'b111;

  // Default FIFO geometry; the occupancy width must hold 0..DEPTH
  localparam int DEFAULT_DEPTH     = 8;
  localparam int DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/fifo_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. A lone request wins outright; on a tie the
// favoured index wins, and after a granted cycle the favoured index becomes
// the one that was not served.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;  // favoured index

  // One-hot grant from the requests and the favoured index
  // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // Move the favour away from the index just served
  // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= 1'b0;
    else if (advance && (grant != 2'b00)) ptr <= grant[0];
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Front-end that shares one FIFO between two producers and two consumers.
// At most one operation issues per cycle; a shadow occupancy count keeps the
// FIFO out of its overflow and underflow error states.
module fifo_port_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            wr_req,
  input  logic [DATA_WIDTH-1:0] wr_din0,
  input  logic [DATA_WIDTH-1:0] wr_din1,
  input  logic [1:0]            rd_req,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [1:0]            wr_ack,
  output logic [1:0]            rd_ack,
  output logic [1:0]            rd_valid,
  output logic [2:0]            op_state,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  full,
  output logic                  empty
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0] wr_cand, rd_cand;
  logic [1:0] wr_gnt, rd_gnt;
  logic       do_wr, do_rd;
  logic       last_rd;              // class served most recently was read
  logic [1:0] rd_pipe [RD_LAT];     // rd_ack delay line toward rd_valid

  // A requester acked this cycle sits out this cycle's evaluation; the
  // occupancy gate keeps writes off a full FIFO and reads off an empty one.
  assign wr_cand = (occupancy < FULL_CNT) ? (wr_req & ~wr_ack) : 2'b00;
  assign rd_cand = (occupancy != '0)      ? (rd_req & ~rd_ack) : 2'b00;

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wr_cand),
    .advance (do_wr),
    .grant   (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rd_cand),
    .advance (do_rd),
    .grant   (rd_gnt)
  );

  // Class selection: a lone class wins, a conflict goes to the class not served last
  always_comb begin
    do_wr = 1'b0;
    do_rd = 1'b0;
    if ((wr_gnt != 2'b00) && ((rd_gnt == 2'b00) || last_rd)) do_wr = 1'b1;
    else if (rd_gnt != 2'b00)                                 do_rd = 1'b1;
  end

  assign full  = (occupancy == FULL_CNT);
  assign empty = (occupancy == '0);

  // Register the chosen operation toward the FIFO and track occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      wr_ack     <= 2'b00;
      rd_ack     <= 2'b00;
      fifo_din   <= '0;
      op_state   <= INIT;
      occupancy  <= '0;
      last_rd    <= 1'b1;
    end else begin
      fifo_wr_en <= do_wr;
      fifo_rd_en <= do_rd;
      wr_ack     <= do_wr ? wr_gnt : 2'b00;
      rd_ack     <= do_rd ? rd_gnt : 2'b00;
      if (do_wr) begin
        fifo_din  <= wr_gnt[1] ? wr_din1 : wr_din0;
        occupancy <= occupancy + CNT_ONE;
        op_state  <= WRITE;
        last_rd   <= 1'b0;
      end else if (do_rd) begin
        occupancy <= occupancy - CNT_ONE;
        op_state  <= READ;
        last_rd   <= 1'b1;
      end else begin
        op_state  <= NO_OP;
      end
    end
  end

  // Delay rd_ack by RD_LAT cycles so rd_valid lines up with FIFO dout
  // NOTE: this small delay line is reset on purpose so a reset flushes any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 2'b00;
    end else begin
      rd_pipe[0] <= rd_ack;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_valid = rd_pipe[RD_LAT-1];

endmodule

// File: doc/fifo_port_arbiter.md
# fifo_port_arbiter

Shares the 8-deep FIFO between two producers and two consumers. Each cycle it issues at most one FIFO operation, a write or a read, chosen by round-robin arbitration. It keeps a shadow occupancy count, so the FIFO is never driven into its write-error (3'b101) or read-error (3'b110) state. It sits directly in front of the FIFO top and drives its wr_en, rd_en and din.

## Interface
- DATA_WIDTH, 32, width of write data
- DEPTH, 8, FIFO capacity; must match the FIFO
- CNT_WIDTH, 4, occupancy width; holds 0..DEPTH
- RD_LAT, 1, cycles from fifo_rd_en to FIFO dout valid
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_req  in  2  per-producer write request; held until the matching wr_ack
- wr_din0  in  DATA_WIDTH  producer 0 data; stable while wr_req[0] is high
- wr_din1  in  DATA_WIDTH  producer 1 data; stable while wr_req[1] is high
- rd_req  in  2  per-consumer read request; held until the matching rd_ack
- fifo_wr_en  out  1  FIFO write enable, registered
- fifo_rd_en  out  1  FIFO read enable, registered
- fifo_din  out  DATA_WIDTH  muxed write data, registered
- wr_ack  out  2  one-hot; producer whose write issues this cycle
- rd_ack  out  2  one-hot; consumer whose read issues this cycle
- rd_valid  out  2  one-hot; consumer that owns FIFO dout this cycle
- op_state  out  3  current operation state
- occupancy  out  CNT_WIDTH  shadow count
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0

## Operation
- Eligibility uses mask-free requests.
  - A requester whose ack is high in the current cycle is masked out of that cycle's evaluation.
  - A held request is therefore re-served at most every second cycle.
- Write candidates: wr_req & ~wr_ack, only when occupancy < DEPTH.
- Read candidates: rd_req & ~rd_ack, only when occupancy > 0.
- Within each class, a round-robin pointer names the favoured index.
  - The favoured index wins ties.
  - After a grant in that class, the pointer moves to the other index.
  - Both pointers reset to index 0.
- Between classes:
  - If only one class has candidates, that class wins.
  - If both have candidates, the class not served last wins.
  - The last-class flag resets to "read", so write wins the first conflict.
- On a grant, the next edge registers:
  - fifo_wr_en or fifo_rd_en (never both),
  - the one-hot ack,
  - fifo_din (write only; otherwise it holds its previous value).
- Occupancy update: write +1, read -1, idle unchanged. It never exceeds DEPTH and never goes below 0.
- rd_valid is rd_ack delayed by exactly RD_LAT cycles through a shift pipeline.
- op_state values:
  - INIT 3'b000 (reset only)
  - WRITE 3'b001
  - READ 3'b010
  - NO_OP 3'b111
- op_state transitions, registered with the enables:
  - WRITE in any cycle where fifo_wr_en is high
  - READ in any cycle where fifo_rd_en is high
  - NO_OP otherwise after reset
  - INIT only until the first clock after reset release

## Timing
- Reset values:
  - enables 0, acks 0, rd_valid 0, fifo_din 0
  - op_state INIT, occupancy 0
  - empty 1, full 0, pointers 0, last-class flag read
- Latency: request seen at edge N produces enable and ack in cycle N+1; the read result reaches rd_valid in cycle N+1+RD_LAT.
- Peak throughput: one operation per cycle when different requesters alternate.
- Full: a write request stalls with no ack; a pending read proceeds; after that read, writes become eligible next cycle.
- Empty: a read request stalls; only writes are eligible.
- Occupancy must not wrap: at DEPTH no write is issued, at 0 no read is issued.
- Reset during operation: everything returns to reset values on assertion, and the rd_valid pipeline is flushed.
  - Requesters must re-request after reset.
  - The FIFO must be reset in the same cycle.

## Structure
- Shared package fifo_pkg holds:
  - op_state encodings INIT, WRITE, READ, NO_OP (same codes the FIFO next-state logic uses)
  - DEPTH and CNT_WIDTH defaults
- One sub-module, rr_arb2: a 2-input round-robin arbiter (req[1:0], advance, pointer register → one-hot grant). It is instantiated twice, once for writers and once for readers.
- Class selection, the occupancy counter, output registers and the rd_valid pipeline live in the top level.

## Test plan
- Reset, then wr_req=2'b01 with wr_din0=32'hA5 held → cycle 1: fifo_wr_en=1, wr_ack=01, fifo_din=A5, op_state=001, occupancy=1.
- Both producers request continuously from empty → grants alternate 01,10,01,… with a write every cycle; at occupancy 8, full=1 and no wr_ack appears while requests stay high.
- occupancy=3, wr_req=01 and rd_req=01 both held → the first conflict grants the write; after that the class alternates W,R,W,R, and occupancy oscillates between 4 and 3.
- empty, rd_req=10 held → no rd_ack and op_state=111; then one write → the read issues 2 cycles later and rd_valid=10 exactly RD_LAT cycles after rd_ack.
- full with rd_req=01 and wr_req=01 → the read issues first (occupancy 7), and the write issues in the following cycle (occupancy 8).
- reset asserted in the cycle fifo_wr_en=1 at occupancy 5 → all outputs are immediately at reset values, occupancy=0, and a rd_valid in flight is cleared.
